// File: rtl/wb_master_pipe.sv
// Command-word driven Wishbone pipelined master: one bus transaction per RD/WR
// command, one response word per command, with per-transaction timeout.
module wb_master_pipe #(
  parameter int AW        = 30,
  parameter int TIMEOUT   = 1024,
  parameter bit INC_RESET = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cmd_stb,
  input  logic [33:0]   i_cmd_word,
  output logic          o_cmd_busy,
  output logic          o_rsp_stb,
  output logic [33:0]   o_rsp_word,
  input  logic          i_rsp_busy,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  localparam logic [1:0] SUB_RD   = 2'b00;
  localparam logic [1:0] SUB_WR   = 2'b01;
  localparam logic [1:0] SUB_ADDR = 2'b10;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          inc_q, inc_d;
  logic          rsp_stb_q, rsp_stb_d;
  logic [33:0]   rsp_word_q, rsp_word_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          rst_pend_q, rst_pend_d;
  logic [29:0]   addr30;
  logic          done;

  always_comb begin
    addr30 = '0;
    addr30[AW-1:0] = i_cmd_word[AW-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    inc_d      = inc_q;
    rsp_stb_d  = rsp_stb_q;
    rsp_word_d = rsp_word_q;
    cnt_d      = cnt_q;
    rst_pend_d = rst_pend_q;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        // The reset announcement takes priority over any waiting command.
        if (rst_pend_q) begin
          rst_pend_d = 1'b0;
          rsp_stb_d  = 1'b1;
          rsp_word_d = {2'b11, 32'h0};
          state_d    = RSP;
        end else if (i_cmd_stb) begin
          case (i_cmd_word[33:32])
            SUB_RD, SUB_WR: begin
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
              we_d    = i_cmd_word[32];
              cnt_d   = '0;
              state_d = REQ;
              if (i_cmd_word[33:32] == SUB_WR) data_d = i_cmd_word[31:0];
            end
            SUB_ADDR: begin
              addr_d     = i_cmd_word[AW-1:0];
              inc_d      = i_cmd_word[30];
              rsp_stb_d  = 1'b1;
              rsp_word_d = {2'b10, 1'b0, i_cmd_word[30], addr30};
              state_d    = RSP;
            end
            default: begin
              rsp_stb_d = 1'b1;
              state_d   = RSP;
              if (i_cmd_word[31:29] == 3'b000) begin
                inc_d      = 1'b0;
                rsp_word_d = {2'b11, 32'h0};
              end else begin
                rsp_word_d = {2'b11, 3'h7, 29'h0};
              end
            end
          endcase
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (i_wb_err) begin
          done       = 1'b1;
          rsp_word_d = {2'b11, 3'h1, 29'h0};
        end else if (i_wb_ack) begin
          done       = 1'b1;
          rsp_word_d = we_q ? {2'b01, 32'h0} : {2'b00, i_wb_data};
          if (inc_q) addr_d = addr_q + AW'(1);
        end else if (cnt_q == CNT_LAST) begin
          done       = 1'b1;
          rsp_word_d = {2'b11, 3'h2, 29'h0};
        end else if (state_q == REQ && !i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = WAIT;
        end
        if (done) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          rsp_stb_d = 1'b1;
          state_d   = RSP;
        end
      end
      default: begin
        if (!i_rsp_busy) begin
          rsp_stb_d = 1'b0;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      inc_q      <= INC_RESET;
      rsp_stb_q  <= 1'b0;
      rsp_word_q <= '0;
      cnt_q      <= '0;
      rst_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      inc_q      <= inc_d;
      rsp_stb_q  <= rsp_stb_d;
      rsp_word_q <= rsp_word_d;
      cnt_q      <= cnt_d;
      rst_pend_q <= rst_pend_d;
    end
  end

  assign o_cmd_busy = (state_q != IDLE) || rst_pend_q;
  assign o_rsp_stb  = rsp_stb_q;
  assign o_rsp_word = rsp_word_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_we    = we_q;
  assign o_wb_addr  = addr_q;
  assign o_wb_data  = data_q;
  assign o_wb_sel   = 4'hF;

endmodule

// File: tb/tb_wb_master_pipe.sv
// Directed bench for wb_master_pipe; a second AW=4 instance shares the inputs
// so the address wrap can be observed.
module tb_wb_master_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_stb = 1'b0;
  logic [33:0] cmd_word = '0;
  logic        rsp_busy = 1'b0;
  logic        wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
  logic [31:0] wb_rdata = '0;

  logic        cmd_busy, rsp_stb, cyc, stb, we;
  logic [33:0] rsp_word;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;

  logic        cmd_busy4, rsp_stb4, cyc4, stb4, we4;
  logic [33:0] rsp_word4;
  logic [3:0]  addr4;
  logic [31:0] wdata4;
  logic [3:0]  sel4;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  wb_master_pipe #(.AW(30), .TIMEOUT(8)) u_dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_cmd_stb(cmd_stb), .i_cmd_word(cmd_word),
    .o_cmd_busy(cmd_busy), .o_rsp_stb(rsp_stb), .o_rsp_word(rsp_word), .i_rsp_busy(rsp_busy),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(addr), .o_wb_data(wdata),
    .o_wb_sel(sel), .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .i_wb_data(wb_rdata)
  );

  wb_master_pipe #(.AW(4), .TIMEOUT(8)) u_dut4 (
    .i_clk(clk), .i_reset_n(reset_n), .i_cmd_stb(cmd_stb), .i_cmd_word(cmd_word),
    .o_cmd_busy(cmd_busy4), .o_rsp_stb(rsp_stb4), .o_rsp_word(rsp_word4), .i_rsp_busy(rsp_busy),
    .o_wb_cyc(cyc4), .o_wb_stb(stb4), .o_wb_we(we4), .o_wb_addr(addr4), .o_wb_data(wdata4),
    .o_wb_sel(sel4), .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .i_wb_data(wb_rdata)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [33:0] w);
    cmd_stb  = 1'b1;
    cmd_word = w;
    tick();
    cmd_stb  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    vectors++;
    if ({cmd_busy, cyc, stb, we, rsp_stb} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctl got %b want 10000", {cmd_busy, cyc, stb, we, rsp_stb});
    end
    vectors++;
    if ({addr, wdata, rsp_word} !== '0 || sel !== 4'hF) begin
      errors++; $display("FAIL reset_regs got addr=%h data=%h rsp=%h sel=%h want 0/0/0/f", addr, wdata, rsp_word, sel);
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h3_0000_0000) begin
      errors++; $display("FAIL reset_announce got stb=%b word=%h want 1 300000000", rsp_stb, rsp_word);
    end
    tick();
    vectors++;
    if (rsp_stb !== 1'b0 || cmd_busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got stb=%b busy=%b want 0 0", rsp_stb, cmd_busy);
    end
  endtask

  task automatic test_addr_read();
    issue(34'h2_4000_0010);
    vectors++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h2_4000_0010 || addr !== 30'h10) begin
      errors++; $display("FAIL addr_rsp got stb=%b word=%h addr=%h want 1 240000010 10", rsp_stb, rsp_word, addr);
    end
    tick();
    issue(34'h0_0000_0000);
    vectors++;
    if ({cyc, stb, we} !== 3'b110 || addr !== 30'h10 || cmd_busy !== 1'b1) begin
      errors++; $display("FAIL rd1_bus got cyc/stb/we=%b addr=%h busy=%b want 110 10 1", {cyc, stb, we}, addr, cmd_busy);
    end
    wb_ack = 1'b1; wb_rdata = 32'hDEADBEEF;
    tick();
    wb_ack = 1'b0;
    vectors++;
    if (cyc !== 1'b0 || rsp_stb !== 1'b1 || rsp_word !== 34'h0_DEAD_BEEF || addr !== 30'h11) begin
      errors++; $display("FAIL rd1_rsp got cyc=%b stb=%b word=%h addr=%h want 0 1 0deadbeef 11", cyc, rsp_stb, rsp_word, addr);
    end
    tick();
    issue(34'h0_0000_0000);
    vectors++;
    if (addr !== 30'h11 || cyc !== 1'b1) begin
      errors++; $display("FAIL rd2_addr got addr=%h cyc=%b want 11 1", addr, cyc);
    end
    wb_ack = 1'b1; wb_rdata = 32'h12345678;
    tick();
    wb_ack = 1'b0;
    vectors++;
    if (rsp_word !== 34'h0_1234_5678 || addr !== 30'h12) begin
      errors++; $display("FAIL rd2_rsp got word=%h addr=%h want 012345678 12", rsp_word, addr);
    end
    tick();
  endtask

  task automatic test_stall_write();
    wb_stall = 1'b1;
    issue(34'h1_CAFE_0001);
    vectors++;
    if ({cyc, stb, we} !== 3'b111 || wdata !== 32'hCAFE0001) begin
      errors++; $display("FAIL wr_start got cyc/stb/we=%b data=%h want 111 cafe0001", {cyc, stb, we}, wdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (stb !== 1'b1 || wdata !== 32'hCAFE0001 || addr !== 30'h12 || we !== 1'b1) begin
        errors++; $display("FAIL wr_stall%0d got stb=%b data=%h addr=%h we=%b want 1 cafe0001 12 1", i, stb, wdata, addr, we);
      end
    end
    wb_stall = 1'b0;
    tick();
    vectors++;
    if ({cyc, stb} !== 2'b10 || rsp_stb !== 1'b0) begin
      errors++; $display("FAIL wr_wait got cyc/stb=%b rsp=%b want 10 0", {cyc, stb}, rsp_stb);
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    vectors++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h1_0000_0000 || addr !== 30'h13) begin
      errors++; $display("FAIL wr_rsp got stb=%b word=%h addr=%h want 1 100000000 13", rsp_stb, rsp_word, addr);
    end
    tick();
  endtask

  task automatic test_ack_err();
    issue(34'h0_0000_0000);
    wb_ack = 1'b1; wb_err = 1'b1;
    tick();
    wb_ack = 1'b0; wb_err = 1'b0;
    vectors++;
    if (rsp_word !== 34'h3_2000_0000 || addr !== 30'h13 || cyc !== 1'b0) begin
      errors++; $display("FAIL ackerr got word=%h addr=%h cyc=%b want 320000000 13 0", rsp_word, addr, cyc);
    end
    tick();
  endtask

  task automatic test_wrap();
    issue(34'h2_4000_000F);
    vectors++;
    if (addr4 !== 4'hF || rsp_word4 !== 34'h2_4000_000F) begin
      errors++; $display("FAIL wrap_addr got addr4=%h word4=%h want f 24000000f", addr4, rsp_word4);
    end
    tick();
    issue(34'h0_0000_0000);
    wb_ack = 1'b1; wb_rdata = 32'h0000_0055;
    tick();
    wb_ack = 1'b0;
    vectors++;
    if (addr4 !== 4'h0 || addr !== 30'h10 || rsp_word4 !== 34'h0_0000_0055) begin
      errors++; $display("FAIL wrap_inc got addr4=%h addr=%h word4=%h want 0 10 000000055", addr4, addr, rsp_word4);
    end
    vectors++;
    if ({cmd_busy4, rsp_stb4, cyc4, stb4, we4} !== 5'b11000 || sel4 !== 4'hF || wdata4 !== 32'hCAFE0001) begin
      errors++; $display("FAIL wrap_ctl got %b sel=%h data=%h want 11000 f cafe0001", {cmd_busy4, rsp_stb4, cyc4, stb4, we4}, sel4, wdata4);
    end
    tick();
  endtask

  task automatic test_timeout();
    issue(34'h0_0000_0000);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (cyc !== 1'b1 || rsp_stb !== 1'b0) begin
        errors++; $display("FAIL tmo_cyc%0d got cyc=%b rsp=%b want 1 0", i, cyc, rsp_stb);
      end
      tick();
    end
    vectors++;
    if (cyc !== 1'b0 || rsp_stb !== 1'b1 || rsp_word !== 34'h3_4000_0000) begin
      errors++; $display("FAIL tmo_rsp got cyc=%b stb=%b word=%h want 0 1 340000000", cyc, rsp_stb, rsp_word);
    end
    wb_ack = 1'b1;
    tick(); tick();
    wb_ack = 1'b0;
    vectors++;
    if (rsp_stb !== 1'b0 || cyc !== 1'b0 || addr !== 30'h10 || cmd_busy !== 1'b0) begin
      errors++; $display("FAIL late_ack got stb=%b cyc=%b addr=%h busy=%b want 0 0 10 0", rsp_stb, cyc, addr, cmd_busy);
    end
  endtask

  task automatic test_rsp_busy();
    rsp_busy = 1'b1;
    issue(34'h3_2000_0000);
    cmd_stb = 1'b1; cmd_word = 34'h2_0000_0003;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (rsp_stb !== 1'b1 || rsp_word !== 34'h3_E000_0000 || cmd_busy !== 1'b1) begin
        errors++; $display("FAIL rspbusy%0d got stb=%b word=%h busy=%b want 1 3e0000000 1", i, rsp_stb, rsp_word, cmd_busy);
      end
      tick();
    end
    cmd_stb = 1'b0; rsp_busy = 1'b0;
    tick();
    vectors++;
    if (rsp_stb !== 1'b0 || cmd_busy !== 1'b0 || addr !== 30'h10) begin
      errors++; $display("FAIL rspbusy_end got stb=%b busy=%b addr=%h want 0 0 10", rsp_stb, cmd_busy, addr);
    end
    issue(34'h3_0000_0000);
    vectors++;
    if (rsp_word !== 34'h3_0000_0000) begin
      errors++; $display("FAIL special0 got word=%h want 300000000", rsp_word);
    end
    tick();
    issue(34'h0_0000_0000);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    vectors++;
    if (addr !== 30'h10) begin
      errors++; $display("FAIL inc_clear got addr=%h want 10", addr);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    issue(34'h0_0000_0000);
    reset_n = 1'b0;
    tick();
    vectors++;
    if ({cyc, stb, rsp_stb} !== 3'b000 || addr !== '0) begin
      errors++; $display("FAIL midrst got cyc/stb/rsp=%b addr=%h want 000 0", {cyc, stb, rsp_stb}, addr);
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if (rsp_stb !== 1'b1 || rsp_word !== 34'h3_0000_0000) begin
      errors++; $display("FAIL midrst_announce got stb=%b word=%h want 1 300000000", rsp_stb, rsp_word);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_addr_read();
    test_stall_write();
    test_ack_err();
    test_wrap();
    test_timeout();
    test_rsp_busy();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/wb_master_pipe.md
WB_MASTER_PIPE -- requirements
Module: wb_master_pipe

Interface
REQ-001 Parameter AW, default 30: Wishbone word-address width, legal range 1..30.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles o_wb_cyc may stay high per transaction, legal range 2..65535.
REQ-003 Parameter INC_RESET, default 0: value of the auto-increment flag after reset.
REQ-004 i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 i_reset_n  input  1  reset, synchronous and active-low.
REQ-006 i_cmd_stb  input  1  command word valid.
REQ-007 i_cmd_word  input  34  command; [33:32] subcode (00 RD, 01 WR, 10 ADDR, 11 SPECIAL), [31:0] payload.
REQ-008 o_cmd_busy  output  1  high = command not accepted this cycle.
REQ-009 o_rsp_stb  output  1  response word valid.
REQ-010 o_rsp_word  output  34  response; [33:32] subcode, [31:0] payload.
REQ-011 i_rsp_busy  input  1  downstream not ready for a response.
REQ-012 o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  Wishbone pipelined-mode cycle, strobe, write enable.
REQ-013 o_wb_addr  output  AW  word address.
REQ-014 o_wb_data  output  32  write data.
REQ-015 o_wb_sel  output  4  byte select, constant 4'hF.
REQ-016 i_wb_stall, i_wb_ack, i_wb_err  input  1 each  slave stall, acknowledge, error.
REQ-017 i_wb_data  input  32  read data.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, RSP; o_cmd_busy SHALL be low only in IDLE.
REQ-019 Command accepted only when i_cmd_stb && state==IDLE; i_cmd_stb outside IDLE ignored.
REQ-020 ADDR: o_wb_addr <= payload[AW-1:0], inc flag <= payload[30]; next state RSP with word {10, 1'b0, inc, zero-extended addr to 30 bits}.
REQ-021 RD: cyc=stb=1, we=0; WR: cyc=stb=1, we=1, o_wb_data <= payload; both registered one cycle after acceptance, state REQ.
REQ-022 REQ: stb SHALL hold with address/data/we stable until a cycle with i_wb_stall==0, then stb<=0 and state WAIT.
REQ-023 i_wb_ack/i_wb_err SHALL be sampled in REQ and WAIT; on either, cyc<=0, stb<=0, state RSP.
REQ-024 Simultaneous ack and err: err wins.
REQ-025 Responses: RD ack {00, i_wb_data}; WR ack {01, 32'h0}; err {11, 3'h1, 29'h0}; timeout {11, 3'h2, 29'h0}.
REQ-026 Timeout counter SHALL clear at cyc rise and count each cycle cyc is high; reaching TIMEOUT with no ack/err drops cyc/stb and emits timeout response.
REQ-027 Ack/err arriving while cyc low SHALL be ignored.
REQ-028 On ack only, if inc flag set, o_wb_addr <= o_wb_addr+1 modulo 2^AW (wrap to 0); no increment on err/timeout.
REQ-029 SPECIAL with payload[31:29]==000: clear inc flag, respond {11, 3'h0, 29'h0}; other SPECIAL codes respond {11, 3'h7, 29'h0}, no other effect.
REQ-030 RSP: o_rsp_stb=1, o_rsp_word stable; transfer completes in a cycle with i_rsp_busy==0; next cycle o_rsp_stb=0, state IDLE.
REQ-031 Exactly one response per accepted command; latency accept-to-o_rsp_stb for ADDR is 1 cycle, for RD/WR ack in first REQ cycle is 2 cycles.

Reset
REQ-032 While i_reset_n==0 at a clock edge: state IDLE, cyc/stb/we 0, o_wb_addr 0, o_wb_data 0, inc=INC_RESET, o_rsp_stb 0, o_rsp_word 0, counter 0, o_cmd_busy 1.
REQ-033 Reset mid-transaction SHALL drop cyc/stb at the next edge without response for the aborted command.
REQ-034 First cycle after reset release SHALL enter RSP with {11, 3'h0, 29'h0} (reset announcement), then IDLE.

Verification
REQ-035 Reset release -> one response 34'h3_0000_0000, then o_cmd_busy low.
REQ-036 ADDR 0x2_4000_0010 (inc=1, addr 0x10), RD twice, slave returns 0xDEADBEEF, 0x12345678 -> responses {00,DEADBEEF} at addr 0x10, {00,12345678} at 0x11.
REQ-037 WR 0x1_CAFE0001 with i_wb_stall high 3 cycles -> stb held 4 cycles, o_wb_data=0xCAFE0001, response 34'h1_0000_0000.
REQ-038 RD, ack and err same cycle -> response 34'h3_2000_0000, address not incremented; ADDR with AW=4, addr 0xF, inc=1, RD ack -> o_wb_addr wraps to 0.
REQ-039 RD with no ack, TIMEOUT=8 -> cyc high 8 cycles, response 34'h3_4000_0000; late ack ignored.
REQ-040 i_rsp_busy high 5 cycles during RSP -> o_rsp_stb and o_rsp_word held; new i_cmd_stb ignored until IDLE.
